// File: rtl/ex_pkg.sv
// Shared widths, alusel encodings and the multiply/divide FSM state type
// for the execute stage.
package ex_pkg;

  localparam int REG_BUS_W       = 32;  // RegBus
  localparam int IMM_BUS_W       = 32;  // ImmBus
  localparam int INST_ADDR_BUS_W = 32;  // InstAddrBus
  localparam int ALU_SEL_BUS_W   = 6;   // AluSelBus
  localparam int MD_CYCLES_DEF   = 32;

  typedef logic [ALU_SEL_BUS_W-1:0] alu_sel_bus_t;

  localparam alu_sel_bus_t ALU_NOP    = 6'd0;
  localparam alu_sel_bus_t ALU_ADD    = 6'd1;
  localparam alu_sel_bus_t ALU_SUB    = 6'd2;
  localparam alu_sel_bus_t ALU_SLL    = 6'd3;
  localparam alu_sel_bus_t ALU_SLT    = 6'd4;
  localparam alu_sel_bus_t ALU_SLTU   = 6'd5;
  localparam alu_sel_bus_t ALU_XOR    = 6'd6;
  localparam alu_sel_bus_t ALU_SRL    = 6'd7;
  localparam alu_sel_bus_t ALU_SRA    = 6'd8;
  localparam alu_sel_bus_t ALU_OR     = 6'd9;
  localparam alu_sel_bus_t ALU_AND    = 6'd10;
  localparam alu_sel_bus_t ALU_ADDI   = 6'd11;
  localparam alu_sel_bus_t ALU_SLTI   = 6'd12;
  localparam alu_sel_bus_t ALU_SLTIU  = 6'd13;
  localparam alu_sel_bus_t ALU_XORI   = 6'd14;
  localparam alu_sel_bus_t ALU_ORI    = 6'd15;
  localparam alu_sel_bus_t ALU_ANDI   = 6'd16;
  localparam alu_sel_bus_t ALU_SLLI   = 6'd17;
  localparam alu_sel_bus_t ALU_SRLI   = 6'd18;
  localparam alu_sel_bus_t ALU_SRAI   = 6'd19;
  localparam alu_sel_bus_t ALU_LUI    = 6'd20;
  localparam alu_sel_bus_t ALU_AUIPC  = 6'd21;
  localparam alu_sel_bus_t ALU_JAL    = 6'd22;
  localparam alu_sel_bus_t ALU_JALR   = 6'd23;
  localparam alu_sel_bus_t ALU_BEQ    = 6'd24;
  localparam alu_sel_bus_t ALU_BNE    = 6'd25;
  localparam alu_sel_bus_t ALU_BLT    = 6'd26;
  localparam alu_sel_bus_t ALU_BGE    = 6'd27;
  localparam alu_sel_bus_t ALU_BLTU   = 6'd28;
  localparam alu_sel_bus_t ALU_BGEU   = 6'd29;
  localparam alu_sel_bus_t ALU_LB     = 6'd30;
  localparam alu_sel_bus_t ALU_LH     = 6'd31;
  localparam alu_sel_bus_t ALU_LW     = 6'd32;
  localparam alu_sel_bus_t ALU_LBU    = 6'd33;
  localparam alu_sel_bus_t ALU_LHU    = 6'd34;
  localparam alu_sel_bus_t ALU_SB     = 6'd35;
  localparam alu_sel_bus_t ALU_SH     = 6'd36;
  localparam alu_sel_bus_t ALU_SW     = 6'd37;
  localparam alu_sel_bus_t ALU_MUL    = 6'd38;
  localparam alu_sel_bus_t ALU_MULH   = 6'd39;
  localparam alu_sel_bus_t ALU_MULHSU = 6'd40;
  localparam alu_sel_bus_t ALU_MULHU  = 6'd41;
  localparam alu_sel_bus_t ALU_DIV    = 6'd42;
  localparam alu_sel_bus_t ALU_DIVU   = 6'd43;
  localparam alu_sel_bus_t ALU_REM    = 6'd44;
  localparam alu_sel_bus_t ALU_REMU   = 6'd45;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  function automatic logic op_is_mul(alu_sel_bus_t op);
    return (op >= ALU_MUL) && (op <= ALU_MULHU);
  endfunction

  function automatic logic op_is_md(alu_sel_bus_t op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on operand
// magnitudes, one step per cycle, sign fixed up when the result is read.
module ex_muldiv import ex_pkg::*; #(
  parameter int XLEN      = REG_BUS_W,
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  alu_sel_bus_t       op,
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result,
  output md_state_e          state
);

  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  md_state_e         state_q, state_d;
  alu_sel_bus_t      op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;   // multiplicand or divisor magnitude
  logic              neg_q, neg_d;   // negate product / quotient
  logic              rneg_q, rneg_d; // negate remainder
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              a_signed, b_signed, a_neg, b_neg, div_ge;
  logic [XLEN-1:0]   a_mag, b_mag, div_sub, quo, rem;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;

    a_signed = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
    b_signed = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;

    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Partial remainder can reach 2*divisor after the shift, so keep its carry bit.
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    div_ge  = rem_sh >= {1'b0, opb_q};
    div_sub = XLEN'(rem_sh - {1'b0, opb_q});

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d    = op;
          cnt_d   = '0;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          state_d = MD_BUSY;
          if (op_is_mul(op)) begin
            acc_d = {{XLEN{1'b0}}, b_mag};
            opb_d = a_mag;
          end else begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            opb_d = b_mag;
          end
        end
      end
      MD_BUSY: begin
        if (op_is_mul(op_q)) begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (div_ge) begin
          acc_d = {div_sub, acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      op_q    <= ALU_NOP;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      ALU_MUL:                        result = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              result = quo;
      default:                        result = rem;
    endcase
  end

  assign busy  = (state_q == MD_BUSY);
  assign done  = (state_q == MD_DONE);
  assign state = state_q;

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle ALU/branch/jump/address logic plus an
// iterative multiply/divide unit that stalls the front of the pipe.
module ex import ex_pkg::*; #(
  parameter int XLEN      = REG_BUS_W,
  parameter int ALU_SEL_W = ALU_SEL_BUS_W,
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALU_SEL_W-1:0] ex_alusel,
  input  logic [XLEN-1:0]      ex_opr1,
  input  logic [XLEN-1:0]      ex_opr2,
  input  logic [XLEN-1:0]      ex_opr3,
  input  logic [XLEN-1:0]      ex_opr4,
  input  logic [4:0]           ex_wd,
  input  logic                 ex_wreg,
  output logic                 ex_stall,
  output logic                 branch_interception,
  output logic [XLEN-1:0]      branch_target,
  output logic [4:0]           mem_wd,
  output logic                 mem_wreg,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [ALU_SEL_W-1:0] mem_op,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_sdata
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic              md_start, md_busy, md_done, md_fast, div_zero, div_ovf;
  logic              lt_s, lt_u;
  logic [XLEN-1:0]   opb, sra_res, md_result, fast_res;
  logic [SH_W-1:0]   shamt;
  md_state_e         md_state;

  ex_muldiv #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (ex_alusel),
    .a      (ex_opr1),
    .b      (ex_opr2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .state  (md_state)
  );

  always_comb begin
    opb     = ((ex_alusel >= ALU_ADDI) && (ex_alusel <= ALU_SRAI)) ? ex_opr3 : ex_opr2;
    shamt   = opb[SH_W-1:0];
    lt_s    = $signed(ex_opr1) < $signed(opb);
    lt_u    = ex_opr1 < opb;
    sra_res = $signed(ex_opr1) >>> shamt;

    // Divide by zero and signed overflow resolve in one cycle without the FSM.
    div_zero = (ex_alusel >= ALU_DIV) && (ex_alusel <= ALU_REMU) && (ex_opr2 == '0);
    div_ovf  = ((ex_alusel == ALU_DIV) || (ex_alusel == ALU_REM)) &&
               (ex_opr1 == INT_MIN) && (ex_opr2 == '1);
    md_fast  = div_zero || div_ovf;
    if (div_zero) fast_res = ((ex_alusel == ALU_DIV) || (ex_alusel == ALU_DIVU)) ? '1 : ex_opr1;
    else          fast_res = (ex_alusel == ALU_DIV) ? INT_MIN : '0;

    md_start = !rst && op_is_md(ex_alusel) && !md_fast && (md_state == MD_IDLE);
  end

  always_comb begin
    ex_stall            = 1'b0;
    branch_interception = 1'b0;
    branch_target       = '0;
    mem_wd              = '0;
    mem_wreg            = 1'b0;
    mem_wdata           = '0;
    mem_op              = '0;
    mem_addr            = '0;
    mem_sdata           = '0;

    if (rst) begin
      ex_stall = 1'b0;
    end else if (md_done) begin
      mem_wd    = ex_wd;
      mem_wreg  = ex_wreg;
      mem_wdata = md_result;
    end else if (md_busy || md_start) begin
      ex_stall = 1'b1;
    end else begin
      mem_wd   = ex_wd;
      mem_wreg = ex_wreg;
      case (ex_alusel)
        ALU_ADD, ALU_ADDI:   mem_wdata = ex_opr1 + opb;
        ALU_SUB:             mem_wdata = ex_opr1 - ex_opr2;
        ALU_SLL, ALU_SLLI:   mem_wdata = ex_opr1 << shamt;
        ALU_SLT, ALU_SLTI:   mem_wdata = {{(XLEN-1){1'b0}}, lt_s};
        ALU_SLTU, ALU_SLTIU: mem_wdata = {{(XLEN-1){1'b0}}, lt_u};
        ALU_XOR, ALU_XORI:   mem_wdata = ex_opr1 ^ opb;
        ALU_SRL, ALU_SRLI:   mem_wdata = ex_opr1 >> shamt;
        ALU_SRA, ALU_SRAI:   mem_wdata = sra_res;
        ALU_OR, ALU_ORI:     mem_wdata = ex_opr1 | opb;
        ALU_AND, ALU_ANDI:   mem_wdata = ex_opr1 & opb;
        ALU_LUI:             mem_wdata = ex_opr3;
        ALU_AUIPC:           mem_wdata = ex_opr4 + ex_opr3;
        ALU_JAL, ALU_JALR: begin
          mem_wdata           = ex_opr4 + XLEN'(4);
          branch_interception = 1'b1;
          branch_target       = (ex_alusel == ALU_JAL) ? ex_opr4 + ex_opr3
                              : (ex_opr1 + ex_opr3) & {{(XLEN-1){1'b1}}, 1'b0};
        end
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
          mem_wreg      = 1'b0;
          branch_target = ex_opr4 + ex_opr3;
          case (ex_alusel)
            ALU_BEQ:  branch_interception = (ex_opr1 == ex_opr2);
            ALU_BNE:  branch_interception = (ex_opr1 != ex_opr2);
            ALU_BLT:  branch_interception = lt_s;
            ALU_BGE:  branch_interception = !lt_s;
            ALU_BLTU: branch_interception = lt_u;
            default:  branch_interception = !lt_u;
          endcase
        end
        ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU: begin
          mem_op   = ex_alusel;
          mem_addr = ex_opr1 + ex_opr3;
        end
        ALU_SB, ALU_SH, ALU_SW: begin
          mem_op    = ex_alusel;
          mem_addr  = ex_opr1 + ex_opr3;
          mem_sdata = ex_opr2;
          mem_wreg  = 1'b0;
        end
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: mem_wdata = fast_res;
        default: begin
          mem_wd   = '0;
          mem_wreg = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Randomized and directed bench for the execute stage, checked every cycle
// against an arithmetic reference model through an expected-value queue.
module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ex_alusel;
  logic [31:0] ex_opr1, ex_opr2, ex_opr3, ex_opr4;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic        ex_stall, branch_interception, mem_wreg;
  logic [31:0] branch_target, mem_wdata, mem_addr, mem_sdata;
  logic [4:0]  mem_wd;
  logic [5:0]  mem_op;

  typedef struct packed {
    logic        stall;
    logic        bi;
    logic [31:0] target;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
  } out_t;
  localparam int EXP_W = $bits(out_t);
  localparam int MD_STALL = 1 + 32;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  out_t             e_cur, a_cur;
  string            nm_cur;

  ex u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_alusel           (ex_alusel),
    .ex_opr1             (ex_opr1),
    .ex_opr2             (ex_opr2),
    .ex_opr3             (ex_opr3),
    .ex_opr4             (ex_opr4),
    .ex_wd               (ex_wd),
    .ex_wreg             (ex_wreg),
    .ex_stall            (ex_stall),
    .branch_interception (branch_interception),
    .branch_target       (branch_target),
    .mem_wd              (mem_wd),
    .mem_wreg            (mem_wreg),
    .mem_wdata           (mem_wdata),
    .mem_op              (mem_op),
    .mem_addr            (mem_addr),
    .mem_sdata           (mem_sdata)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic out_t mk(logic stall, logic bi, logic [31:0] tgt, logic [4:0] wd,
                              logic wreg, logic [31:0] wdata, logic [5:0] op,
                              logic [31:0] addr, logic [31:0] sdata);
    return {stall, bi, tgt, wd, wreg, wdata, op, addr, sdata};
  endfunction

  function automatic bit is_slow(logic [5:0] op, logic [31:0] a, logic [31:0] b);
    if (op >= ALU_MUL && op <= ALU_MULHU) return 1'b1;
    if (op >= ALU_DIV && op <= ALU_REMU) begin
      if (b == 32'd0) return 1'b0;
      if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic out_t model(logic [5:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] imm, logic [31:0] pc, logic [4:0] wd, logic wreg);
    out_t        r;
    longint      sa, sb, sx, ub, ux;
    logic [31:0] x;
    logic [63:0] p;
    int          sh;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    x  = (op >= ALU_ADDI && op <= ALU_SRAI) ? imm : b;
    sx = longint'($signed(x));
    ux = longint'({32'd0, x});
    sh = int'(x % 32);
    r.wd   = wd;
    r.wreg = wreg;
    case (op)
      ALU_ADD, ALU_ADDI:   r.wdata = 32'(sa + sx);
      ALU_SUB:             r.wdata = 32'(sa - sb);
      ALU_SLL, ALU_SLLI:   r.wdata = 32'(longint'({32'd0, a}) * (64'd1 << sh));
      ALU_SRL, ALU_SRLI:   r.wdata = 32'(longint'({32'd0, a}) / (64'd1 << sh));
      ALU_SRA, ALU_SRAI:   r.wdata = 32'(sa >>> sh);
      ALU_SLT, ALU_SLTI:   r.wdata = (sa < sx) ? 32'd1 : 32'd0;
      ALU_SLTU, ALU_SLTIU: r.wdata = (longint'({32'd0, a}) < ux) ? 32'd1 : 32'd0;
      ALU_XOR, ALU_XORI:   r.wdata = a ^ x;
      ALU_OR, ALU_ORI:     r.wdata = a | x;
      ALU_AND, ALU_ANDI:   r.wdata = a & x;
      ALU_LUI:             r.wdata = imm;
      ALU_AUIPC:           r.wdata = pc + imm;
      ALU_JAL: begin r.wdata = pc + 32'd4; r.target = pc + imm; r.bi = 1'b1; end
      ALU_JALR: begin r.wdata = pc + 32'd4; r.target = (a + imm) & 32'hFFFF_FFFE; r.bi = 1'b1; end
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
        r.wreg   = 1'b0;
        r.target = pc + imm;
        case (op)
          ALU_BEQ:  r.bi = (a == b);
          ALU_BNE:  r.bi = (a != b);
          ALU_BLT:  r.bi = (sa < sb);
          ALU_BGE:  r.bi = (sa >= sb);
          ALU_BLTU: r.bi = (longint'({32'd0, a}) < ub);
          default:  r.bi = (longint'({32'd0, a}) >= ub);
        endcase
      end
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU: begin r.op = op; r.addr = a + imm; end
      ALU_SB, ALU_SH, ALU_SW: begin r.op = op; r.addr = a + imm; r.sdata = b; r.wreg = 1'b0; end
      ALU_MUL:    begin p = {32'd0, a} * {32'd0, b}; r.wdata = p[31:0]; end
      ALU_MULH:   begin p = 64'(sa * sb); r.wdata = p[63:32]; end
      ALU_MULHSU: begin p = 64'(sa * ub); r.wdata = p[63:32]; end
      ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r.wdata = p[63:32]; end
      ALU_DIV:    r.wdata = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      ALU_DIVU:   r.wdata = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:    r.wdata = (b == 0) ? a : 32'(sa % sb);
      ALU_REMU:   r.wdata = (b == 0) ? a : a % b;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic push(input out_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur  = out_t'(exp_q.pop_front());
      nm_cur = name_q.pop_front();
      a_cur  = {ex_stall, branch_interception, branch_target, mem_wd, mem_wreg,
                mem_wdata, mem_op, mem_addr, mem_sdata};
      n_checks++;
      if (a_cur !== e_cur) begin
        n_fail++;
        $display("FAIL %s: got stall=%0b br=%0b tgt=%h wd=%0d wreg=%0b wdata=%h op=%0d addr=%h sdata=%h | want stall=%0b br=%0b tgt=%h wd=%0d wreg=%0b wdata=%h op=%0d addr=%h sdata=%h",
                 nm_cur, a_cur.stall, a_cur.bi, a_cur.target, a_cur.wd, a_cur.wreg, a_cur.wdata,
                 a_cur.op, a_cur.addr, a_cur.sdata, e_cur.stall, e_cur.bi, e_cur.target, e_cur.wd,
                 e_cur.wreg, e_cur.wdata, e_cur.op, e_cur.addr, e_cur.sdata);
      end
    end
  end

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] wd, input logic wreg, input int n_stall, input out_t fin);
    out_t st;
    st = mk(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0; ex_alusel = op; ex_opr1 = a; ex_opr2 = b; ex_opr3 = imm; ex_opr4 = pc;
    ex_wd = wd; ex_wreg = wreg;
    for (int i = 0; i < n_stall; i++) begin
      push(st, {nm, "_stall"});
      @(posedge clk); #1;
    end
    push(fin, nm);
  endtask

  task automatic issue_model(input string nm, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                             input logic [4:0] wd, input logic wreg);
    issue(nm, op, a, b, imm, pc, wd, wreg, is_slow(op, a, b) ? MD_STALL : 0,
          model(op, a, b, imm, pc, wd, wreg));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      push('0, "reset");
    end
  endtask

  // ---------------- stimulus ----------------
  logic [5:0]  r_op;
  logic [31:0] r_a, r_b, r_imm, r_pc;

  initial begin
    rst = 1'b1; ex_alusel = ALU_ADD; ex_opr1 = 32'd5; ex_opr2 = 32'd9;
    ex_opr3 = 32'd1; ex_opr4 = 32'h100; ex_wd = 5'd4; ex_wreg = 1'b1;
    do_reset(3);

    // model pins against hand-computed values
    check_val("pin_mulhsu", model(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0).wdata, 32'hFFFF_FFFF);
    check_val("pin_srai",   model(ALU_SRAI, 32'h8000_0000, 0, 32'd4, 0, 0, 0).wdata, 32'hF800_0000);
    check_val("pin_rem",    model(ALU_REM, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0).wdata, 32'hFFFF_FFFF);

    // directed cases with literal expectations
    issue("add", ALU_ADD, 32'd5, 32'hFFFF_FFFE, 0, 0, 5'd3, 1'b1, 0,
          mk(0, 0, 0, 5'd3, 1, 32'd3, 0, 0, 0));
    issue("blt", ALU_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5, 1'b1, 0,
          mk(0, 1, 32'h120, 5'd5, 0, 0, 0, 0, 0));
    issue("bltu", ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5, 1'b1, 0,
          mk(0, 0, 32'h120, 5'd5, 0, 0, 0, 0, 0));
    issue("jalr", ALU_JALR, 32'h1001, 0, 32'd4, 32'h40, 5'd1, 1'b1, 0,
          mk(0, 1, 32'h1004, 5'd1, 1, 32'h44, 0, 0, 0));
    issue("mulh", ALU_MULH, 32'h8000_0000, 32'd2, 0, 0, 5'd7, 1'b1, MD_STALL,
          mk(0, 0, 0, 5'd7, 1, 32'hFFFF_FFFF, 0, 0, 0));
    issue("div_by_zero", ALU_DIV, 32'd7, 32'd0, 0, 0, 5'd8, 1'b1, 0,
          mk(0, 0, 0, 5'd8, 1, 32'hFFFF_FFFF, 0, 0, 0));
    issue("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd9, 1'b1, 0,
          mk(0, 0, 0, 5'd9, 1, 32'd0, 0, 0, 0));
    issue("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd9, 1'b1, 0,
          mk(0, 0, 0, 5'd9, 1, 32'h8000_0000, 0, 0, 0));
    issue("mul_x0", ALU_MUL, 32'd3, 32'd4, 0, 0, 5'd9, 1'b0, MD_STALL,
          mk(0, 0, 0, 5'd9, 0, 32'd12, 0, 0, 0));
    issue("lw", ALU_LW, 32'h1000, 32'h55, 32'hFFFF_FFFC, 0, 5'd2, 1'b1, 0,
          mk(0, 0, 0, 5'd2, 1, 0, ALU_LW, 32'h0FFC, 0));
    issue("sw", ALU_SW, 32'h2000, 32'hCAFE, 32'd8, 0, 5'd2, 1'b1, 0,
          mk(0, 0, 0, 5'd2, 0, 0, ALU_SW, 32'h2008, 32'hCAFE));
    issue("unknown_op", 6'd63, 32'd1, 32'd2, 32'd3, 32'd4, 5'd6, 1'b1, 0, '0);

    // DIVU aborted by reset in the tenth BUSY cycle, then rerun in full
    issue("divu_abort", ALU_DIVU, 32'd100, 32'd7, 0, 0, 5'd10, 1'b1, 9,
          mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1; ex_alusel = ALU_NOP;
    push('0, "rst_in_busy");
    @(posedge clk); #1;
    rst = 1'b0;
    push('0, "after_rst");
    issue("divu", ALU_DIVU, 32'd100, 32'd7, 0, 0, 5'd10, 1'b1, MD_STALL,
          mk(0, 0, 0, 5'd10, 1, 32'd14, 0, 0, 0));

    // randomized instructions against the model
    for (int n = 0; n < 300; n++) begin
      r_op  = 6'($urandom_range(0, 63));
      r_a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'hFFFF_FFFF;
        2:       r_b = r_a;
        default: r_b = $urandom;
      endcase
      r_imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      r_pc  = $urandom & 32'hFFFF_FFFC;
      issue_model($sformatf("rnd%0d_op%0d", n, r_op), r_op, r_a, r_b, r_imm, r_pc,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    ex_alusel = ALU_NOP;
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex.md
Name: ex

Overview:
- Execute stage. Consumes the registered decode bundle from the ID/EX pipeline register.
- Computes RV32I ALU, branch and jump results and the address for each load/store, which it passes on to the EX/MEM register.
- Adds an iterative RV32M multiply/divide unit that asserts ex_stall while busy.
- Generates branch_interception, which flushes the upstream pipeline registers.

Parameters:
- XLEN, 32, datapath width.
- ALU_SEL_W, 6, width of ex_alusel. Must equal the AluSelBus width.
- MD_CYCLES, 32, number of iterations per multiply/divide.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ex_alusel  in  ALU_SEL_W  operation code. 0 = NOP.
- ex_opr1  in  XLEN  rs1 value.
- ex_opr2  in  XLEN  rs2 value.
- ex_opr3  in  XLEN  sign-extended immediate.
- ex_opr4  in  XLEN  instruction PC.
- ex_wd  in  5  destination register.
- ex_wreg  in  1  destination-write enable.
- ex_stall  out  1  high while the multiply/divide unit holds the instruction. ID/EX and the upstream stages freeze their contents.
- branch_interception  out  1  taken branch or jump. Upstream stages flush.
- branch_target  out  XLEN  redirect PC.
- mem_wd  out  5  destination register passed to EX/MEM.
- mem_wreg  out  1  destination-write enable passed to EX/MEM.
- mem_wdata  out  XLEN  result passed to EX/MEM.
- mem_op  out  ALU_SEL_W  alusel forwarded for load/store instructions, 0 otherwise.
- mem_addr  out  XLEN  opr1+opr3 for load/store instructions.
- mem_sdata  out  XLEN  opr2 for store instructions.

Behaviour:
- Reset values: all outputs 0, MD FSM in IDLE, iteration counter 0.
- Single-cycle ops (combinational, zero latency, ex_stall=0):
  - LUI: wdata = opr3.
  - AUIPC: wdata = opr4+opr3.
  - R-type ALU ops use opr2 as the second operand. I-type ALU ops use opr3.
  - Shifts use bits [4:0] of the shift amount.
  - SLT/SLTI compare signed. SLTU/SLTIU compare unsigned.
- JAL:
  - wdata = opr4+4.
  - branch_target = opr4+opr3.
  - branch_interception = 1.
- JALR:
  - wdata = opr4+4.
  - branch_target = (opr1+opr3) with bit 0 cleared.
  - branch_interception = 1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - branch_target = opr4+opr3.
  - branch_interception = 1 only when the condition holds.
  - mem_wreg = 0.
- Loads and stores:
  - mem_addr and mem_op are valid.
  - Stores force mem_wreg = 0.
  - Loads pass ex_wreg through unchanged.
- NOP or an unknown alusel: all outputs 0.
- All arithmetic wraps modulo 2^XLEN.
- MD FSM states: IDLE, BUSY, DONE.
  - IDLE, M-op present, no fast path: latch operands and signedness, counter = 0, go to BUSY.
    - This cycle: ex_stall = 1, mem_wreg = 0.
  - BUSY: one shift-add or restoring-subtract step per cycle; counter increments.
    - Leave for DONE when counter = MD_CYCLES-1.
    - ex_stall = 1 and mem_wreg = 0 throughout.
  - DONE: ex_stall = 0; drive mem_wd, mem_wreg and mem_wdata = result; go to IDLE on the next edge.
  - Total: 1 + MD_CYCLES cycles with ex_stall high; the result appears in cycle MD_CYCLES+1.
- Result selection:
  - MUL: low word.
  - MULH / MULHSU / MULHU: high word.
  - Signed forms operate on magnitudes, then correct the sign.
- Division fast paths: single cycle, no stall.
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - DIV overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- Inputs are ignored while BUSY or DONE, because upstream is frozen by ex_stall.
- branch_interception can never coincide with ex_stall = 1.
- rst during BUSY or DONE: abort the operation, return to IDLE, drop the result; ex_stall = 0 on the following cycle.
- An M-op with ex_wreg = 0 (rd = x0) still iterates, but mem_wreg stays 0.

Decomposition:
- Alusel encodings live in the shared defines file, alongside the AluSelBus, RegBus, ImmBus and InstAddrBus widths. New encodings:
  - ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU.
  - ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- One sub-module, ex_muldiv, holds the FSM, the 64-bit accumulator/remainder and the counter.
  - Interface: start, op, a, b → busy, done, result.
  - ex instantiates it and muxes its result into mem_wdata.

Test Plan:
- ADD with opr1=5, opr2=0xFFFFFFFE, wd=3 → mem_wdata=3, mem_wreg=1, mem_wd=3, same cycle, ex_stall=0.
- BLT with opr1=0xFFFFFFFF (-1), opr2=1, opr4=0x100, opr3=0x20 → branch_interception=1, branch_target=0x120, mem_wreg=0. BLTU with the same operands → branch_interception=0.
- JALR with opr1=0x1001, opr3=4, opr4=0x40 → branch_target=0x1004, mem_wdata=0x44.
- MULH with opr1=0x80000000, opr2=2 → ex_stall high 33 cycles, then mem_wdata=0xFFFFFFFF for 1 cycle; inputs held constant during the stall.
- DIV with 7/0 → mem_wdata=0xFFFFFFFF with no stall. REM with 0x80000000 / 0xFFFFFFFF → mem_wdata=0, no stall.
- DIVU 100/7 started, rst asserted in BUSY cycle 10 → all outputs 0 next cycle. A fresh DIVU 100/7 afterwards → mem_wdata=14 after the full latency.
